csel_serial_addsub: RTL and testbench
=====================================

Name: csel_serial_addsub

Overview:
- Block-serial carry-select adder/subtractor. Splits WIDTH-bit operands into BLOCK-bit slices and processes one slice per clock, LSB slice first.
- For each slice it forms both candidate sums (carry-in 0 and carry-in 1), then selects one using the registered carry from the previous slice.
- Sits on the consumer side of the dual-sum slice logic in the carry-select datapath. Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of BLOCK.
- BLOCK, 8, slice width processed per cycle; NBLK = WIDTH/BLOCK must be at least 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b+c_in; 1: a-b-c_in (c_in acts as borrow-in).
- c_in  input  1  carry-in, or borrow-in when sub=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum or difference.
- c_out  output  1  carry-out; borrow-out when sub=1.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, s=0, c_out=0, ovf=0, internal working registers=0. in_ready=0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A=a and B=(sub ? ~b : b).
  - Latch carry register C=(sub ? ~c_in : c_in) and sub_q=sub.
  - Clear slice index k=0; go to RUN.
- RUN (in_ready=0), each cycle:
  - Compute s0={co0,sum0}=A[k]+B[k]+0 and s1={co1,sum1}=A[k]+B[k]+1, both BLOCK+1 bits.
  - Write sel=C ? s1 : s0 into working result W[k]; set C=sel carry.
  - On the last slice (k==NBLK-1), also capture the carry into the MSB: cm = A[MSB]^B[MSB]^W[MSB].
  - k increments; after the slice with k=NBLK-1, go to DONE.
- Entering DONE:
  - s=W.
  - c_out=(sub_q ? ~C : C).
  - ovf=cm^C (raw carry, not inverted).
  - out_valid=1.
- Latency: operands accepted on edge 0; out_valid is high after edge NBLK.
- DONE:
  - out_valid held high; s, c_out, ovf held stable until out_valid&out_ready.
  - On that handshake: out_valid=0 on the next edge; go to IDLE.
- Throughput: one operation per NBLK+2 cycles minimum. No overlap: in_ready is low in RUN and DONE, and in_valid is ignored there.
- s, c_out and ovf keep the last result after the handshake and change only on the next DONE entry.
- Operands a, b, sub and c_in need only be stable on the accepting edge.
- NBLK=1: RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE: immediate return to reset values. No partial result is ever presented; no output appears after reset release without a new accept.
- Arithmetic is modulo 2^WIDTH. Slice carries never leave the BLOCK+1-bit slice adder except through C.

Test Plan:
- WIDTH=32, BLOCK=8, add a=0x0000_00FF, b=0x1, c_in=0 -> s=0x0000_0100, c_out=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Full ripple: add a=0xFFFF_FFFF, b=0, c_in=1 -> s=0x0000_0000, c_out=1, ovf=0. This exercises the carry crossing every slice boundary.
- Subtract cases:
  - a=5, b=7, sub=1, c_in=0 -> s=0xFFFF_FFFE, c_out(borrow)=1, ovf=0.
  - a=0x8000_0000, b=1, sub=1 -> s=0x7FFF_FFFF, c_out=0, ovf=1.
- Signed overflow on add: a=0x7FFF_FFFF, b=1, c_in=0 -> s=0x8000_0000, c_out=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands.
  - out_valid stays 1, s and flags stay constant, in_ready stays 0, and the new operands are not taken.
  - After out_ready=1: IDLE next cycle; the new operands are accepted and give a correct second result.
- Reset mid-operation: drop rst_n asynchronously after 2 RUN cycles.
  - out_valid=0 and s=0 immediately.
  - After release, in_ready=1 and no out_valid until a fresh operation completes. That operation gives the correct result, with no stale carry.

Source files
------------

// File: rtl/csel_serial_addsub_if.sv
// Operand/result handshake bundle for the block-serial carry-select adder/subtractor.
// master drives operands and consumes results; slave is the arithmetic block.
interface csel_serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/csel_serial_addsub.sv
// Block-serial carry-select adder/subtractor: one BLOCK-bit slice per clock, LSB first,
// choosing between precomputed carry-in-0/1 slice sums with the registered slice carry.
module csel_serial_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  csel_serial_addsub_if.slave bus
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned SW   = BLOCK + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             c_q, c_d;
  logic             sub_q, sub_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [BLOCK-1:0] a_sl_c;
  logic [BLOCK-1:0] b_sl_c;
  logic [SW-1:0]    sum0_c;
  logic [SW-1:0]    sum1_c;
  logic [SW-1:0]    sel_c;
  logic [WIDTH-1:0] w_upd_c;
  logic             last_c;
  logic             cm_c;

  // Current slice of the latched operands, picked by the slice index.
  always_comb begin
    a_sl_c = '0;
    b_sl_c = '0;
    for (int unsigned i = 0; i < NBLK; i++) begin
      if (k_q == KW'(i)) begin
        a_sl_c = a_q[i*BLOCK +: BLOCK];
        b_sl_c = b_q[i*BLOCK +: BLOCK];
      end
    end
  end

  // Dual slice sums, selected by the carry coming out of the previous slice.
  assign sum0_c = {1'b0, a_sl_c} + {1'b0, b_sl_c};
  assign sum1_c = sum0_c + SW'(1);
  assign sel_c  = c_q ? sum1_c : sum0_c;
  assign last_c = (k_q == KW'(NBLK - 1));
  // Carry into the result MSB, recovered from the MSB sum bit of the last slice.
  assign cm_c   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sel_c[BLOCK-1];

  always_comb begin
    w_upd_c = w_q;
    for (int unsigned i = 0; i < NBLK; i++) begin
      if (k_q == KW'(i)) begin
        w_upd_c[i*BLOCK +: BLOCK] = sel_c[BLOCK-1:0];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    w_d         = w_q;
    c_d         = c_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub ^ bus.c_in;
          sub_d   = bus.sub;
          k_d     = '0;
          w_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        w_d = w_upd_c;
        c_d = sel_c[BLOCK];
        k_d = k_q + KW'(1);
        if (last_c) begin
          k_d         = '0;
          s_d         = w_upd_c;
          c_out_d     = sub_q ^ sel_c[BLOCK];
          ovf_d       = cm_c ^ sel_c[BLOCK];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      c_q         <= 1'b0;
      sub_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      w_q         <= w_d;
      c_q         <= c_d;
      sub_q       <= sub_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_csel_serial_addsub.sv
// Bench for csel_serial_addsub: directed vector table, hand-written corner sequences and
// random operations against a plain-arithmetic reference model.
module tb_csel_serial_addsub;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BLOCK = 8;
  localparam int unsigned NBLK  = WIDTH / BLOCK;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csel_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  csel_serial_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic; overflow from operand/result signs.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input logic cin, output logic [31:0] s, output logic c,
                                output logic o);
    logic [32:0] r;
    if (!sub) r = {1'b0, a} + {1'b0, b} + 33'(cin);
    else      r = {1'b0, a} - {1'b0, b} - 33'(cin);
    s = r[31:0];
    c = r[32];
    if (!sub) o = (a[31] == b[31]) && (s[31] != a[31]);
    else      o = (a[31] != b[31]) && (s[31] != a[31]);
  endfunction

  // Present one operand set and return at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.c_in     = cin;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.sub      = 1'($urandom);
    bus.c_in     = 1'($urandom);
  endtask

  task automatic collect(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_handshake", 64'(bus.out_valid), 64'(0));
    check("in_ready_after_handshake", 64'(bus.in_ready), 64'(1));
  endtask

  task automatic check_result(input string tag, input logic [31:0] es, input logic ec,
                              input logic eo, input int lat);
    check({tag, "_latency"}, 64'(lat), 64'(NBLK));
    check({tag, "_s"}, 64'(bus.s), 64'(es));
    check({tag, "_c_out"}, 64'(bus.c_out), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
  endtask

  task automatic run_model_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic sub, input logic cin);
    logic [31:0] es;
    logic ec, eo;
    int lat;
    model(a, b, sub, cin, es, ec, eo);
    issue(a, b, sub, cin);
    collect(lat);
    check_result(tag, es, ec, eo, lat);
    release_result();
  endtask

  initial begin
    logic [31:0] es, s_hold, ra, rb;
    logic ec, eo, c_hold, o_hold, rsub, rcin;
    int lat, d;
    logic [31:0] corners[4];

    vecs[0] = '{a: 32'h0000_00FF, b: 32'h0000_0001, sub: 1'b0, cin: 1'b0,
                s: 32'h0000_0100, c: 1'b0, o: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, sub: 1'b0, cin: 1'b1,
                s: 32'h0000_0000, c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 32'h0000_0005, b: 32'h0000_0007, sub: 1'b1, cin: 1'b0,
                s: 32'hFFFF_FFFE, c: 1'b1, o: 1'b0};
    vecs[3] = '{a: 32'h8000_0000, b: 32'h0000_0001, sub: 1'b1, cin: 1'b0,
                s: 32'h7FFF_FFFF, c: 1'b0, o: 1'b1};
    vecs[4] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, sub: 1'b0, cin: 1'b0,
                s: 32'h8000_0000, c: 1'b0, o: 1'b1};
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.c_in      = 1'b0;
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_s", 64'(bus.s), 64'(0));
    check("reset_c_out", 64'(bus.c_out), 64'(0));
    check("reset_ovf", 64'(bus.ovf), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      collect(lat);
      check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].o, lat);
      release_result();
    end

    // Backpressure: result held while new operands wait at the input.
    model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, es, ec, eo);
    issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1);
    collect(lat);
    check_result("bp_first", es, ec, eo, lat);
    s_hold = bus.s;
    c_hold = bus.c_out;
    o_hold = bus.ovf;
    bus.in_valid = 1'b1;
    bus.a        = 32'h0001_0000;
    bus.b        = 32'h0000_00F0;
    bus.sub      = 1'b1;
    bus.c_in     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_s_stable", 64'(bus.s), 64'(s_hold));
      check("bp_flags_stable", 64'({bus.c_out, bus.ovf}), 64'({c_hold, o_hold}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_out_valid_dropped", 64'(bus.out_valid), 64'(0));
    check("bp_idle_in_ready", 64'(bus.in_ready), 64'(1));
    check("bp_s_kept", 64'(bus.s), 64'(s_hold));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    model(32'h0001_0000, 32'h0000_00F0, 1'b1, 1'b1, es, ec, eo);
    collect(lat);
    check_result("bp_second", es, ec, eo, lat);
    release_result();

    // Reset during RUN with a carry rippling through every slice.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_s", 64'(bus.s), 64'(0));
    check("midrst_flags", 64'({bus.c_out, bus.ovf}), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_no_out_valid", 64'(bus.out_valid), 64'(0));
    end
    check("postrst_in_ready", 64'(bus.in_ready), 64'(1));
    run_model_op("postrst", 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);

    // Random operations, with occasional corner operands and random consumer stalls.
    for (int i = 0; i < 150; i++) begin
      ra   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      rb   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      rsub = 1'($urandom);
      rcin = 1'($urandom);
      model(ra, rb, rsub, rcin, es, ec, eo);
      issue(ra, rb, rsub, rcin);
      collect(lat);
      check_result($sformatf("rnd%0d", i), es, ec, eo, lat);
      d = $urandom_range(0, 2);
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        check("rnd_hold_s", 64'(bus.s), 64'(es));
      end
      release_result();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
